// File: rtl/stall_ctrl_pkg.sv
// Shared stall-control definitions: pipeline register control codes, arbiter states, hazard helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package stall_ctrl_pkg;

   localparam int REG_IDX_W = 5;

   // Control code applied by every pipeline register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB)
   typedef enum logic [1:0] {
      NORMAL = 2'b00,
      STALL  = 2'b01,
      BUBBLE = 2'b10
   } stl_code_t;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_SRV_IF  = 2'b01,
      ARB_SRV_MEM = 2'b10
   } arb_state_t;

   typedef struct packed {
      stl_code_t pc;
      stl_code_t if_id;
      stl_code_t id_ex;
      stl_code_t ex_mem;
      stl_code_t mem_wb;
   } stl_vec_t;

   function automatic stl_vec_t stl_all(input stl_code_t c);
      stl_vec_t v;
      v.pc     = c;
      v.if_id  = c;
      v.id_ex  = c;
      v.ex_mem = c;
      v.mem_wb = c;
      return v;
   endfunction

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   function automatic logic raw_hit(
      input logic                 ld,
      input logic [REG_IDX_W-1:0] rd,
      input logic [REG_IDX_W-1:0] rs1,
      input logic                 use1,
      input logic [REG_IDX_W-1:0] rs2,
      input logic                 use2
   );
      return ld && (rd != '0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single memory port arbiter between IF and MEM (MEM wins ties); also tracks fetches to be dropped.
// Latency: grant registered, high the cycle after leaving IDLE, low the cycle after done.
// Backpressure: requester holds its request until done; done outside a service state is ignored.
module mem_arbiter
   import stall_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_if,
   input  logic       req_mem,
   input  logic       done,
   input  logic       br,
   output logic       gnt_if,
   output logic       gnt_mem,
   output arb_state_t state,
   output logic       flush_pend
);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_IDLE;
         gnt_if     <= 1'b0;
         gnt_mem    <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (req_mem) begin
                  state   <= ARB_SRV_MEM;
                  gnt_mem <= 1'b1;
               end else if (req_if) begin
                  state   <= ARB_SRV_IF;
                  gnt_if  <= 1'b1;
                  // a branch resolving as the fetch starts makes that fetch stale
                  if (br) begin
                     flush_pend <= 1'b1;
                  end
               end
            end
            ARB_SRV_IF: begin
               if (done) begin
                  state      <= ARB_IDLE;
                  gnt_if     <= 1'b0;
                  flush_pend <= 1'b0;
               end else if (br) begin
                  flush_pend <= 1'b1;
               end
            end
            ARB_SRV_MEM: begin
               if (done) begin
                  state   <= ARB_IDLE;
                  gnt_mem <= 1'b0;
               end
            end
            default: begin
               state      <= ARB_IDLE;
               gnt_if     <= 1'b0;
               gnt_mem    <= 1'b0;
               flush_pend <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use, branch flush and memory-port stalls (STALL_PERF_CNT_EN adds perf counters).
// Latency: stall codes are combinational from arbiter state and inputs; grants are registered.
// Backpressure: outstanding memory accesses hold upstream registers (STALL) and inject BUBBLEs downstream.
module stall_ctrl
   import stall_ctrl_pkg::*;
`ifdef STALL_PERF_CNT_EN
#(
   parameter int unsigned CNT_W = 32
)
`endif
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld_EX_i,
   input  logic [REG_IDX_W-1:0] rd_EX_i,
   input  logic [REG_IDX_W-1:0] rs1_ID_i,
   input  logic [REG_IDX_W-1:0] rs2_ID_i,
   input  logic                 rs1_use_ID_i,
   input  logic                 rs2_use_ID_i,
   input  logic                 br_EX_i,
   input  logic                 req_IF_i,
   input  logic                 req_MEM_i,
   input  logic                 done_MEMCTRL_i,
   output logic                 gnt_IF_o,
   output logic                 gnt_MEM_o,
   output logic [1:0]           stl_PC_o,
   output logic [1:0]           stl_IF_ID_o,
   output logic [1:0]           stl_ID_EX_o,
   output logic [1:0]           stl_EX_MEM_o,
   output logic [1:0]           stl_MEM_WB_o
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]     cnt_stall_o,
   output logic [CNT_W-1:0]     cnt_bubble_o
`endif
);

   arb_state_t arb_st;
   logic       flush_pend;
   logic       mem_wait;
   logic       fetch_done;
   logic       if_wait;
   logic       flush_drop;
   logic       load_use;
   stl_vec_t   stl;

   mem_arbiter u_arb (
      .clk        (clk),
      .rst        (rst),
      .req_if     (req_IF_i),
      .req_mem    (req_MEM_i),
      .done       (done_MEMCTRL_i),
      .br         (br_EX_i),
      .gnt_if     (gnt_IF_o),
      .gnt_mem    (gnt_MEM_o),
      .state      (arb_st),
      .flush_pend (flush_pend)
   );

   assign mem_wait   = ((arb_st == ARB_SRV_MEM) && !done_MEMCTRL_i) ||
                       ((arb_st == ARB_IDLE) && req_MEM_i);
   assign fetch_done = (arb_st == ARB_SRV_IF) && done_MEMCTRL_i;
   // IF is waiting while it requests or is being served, until its own done
   assign if_wait    = (req_IF_i || (arb_st == ARB_SRV_IF)) && !fetch_done;
   assign flush_drop = fetch_done && flush_pend;
   assign load_use   = raw_hit(ld_EX_i, rd_EX_i, rs1_ID_i, rs1_use_ID_i, rs2_ID_i, rs2_use_ID_i);

   always_comb begin
      stl = stl_all(NORMAL);
      if (rst) begin
         stl = stl_all(BUBBLE);
      end else if (mem_wait) begin
         stl        = stl_all(STALL);
         stl.mem_wb = BUBBLE;
      end else if (br_EX_i) begin
         // also overrides a same-cycle load-use: the dependent instruction is flushed
         stl.if_id = BUBBLE;
         stl.id_ex = BUBBLE;
      end else if (if_wait) begin
         stl.pc    = STALL;
         stl.if_id = BUBBLE;
      end else if (flush_drop) begin
         stl.if_id = BUBBLE;
      end else if (load_use) begin
         stl.pc    = STALL;
         stl.if_id = STALL;
         stl.id_ex = BUBBLE;
      end
   end

   assign stl_PC_o     = stl.pc;
   assign stl_IF_ID_o  = stl.if_id;
   assign stl_ID_EX_o  = stl.id_ex;
   assign stl_EX_MEM_o = stl.ex_mem;
   assign stl_MEM_WB_o = stl.mem_wb;

`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_stall_q;
   logic [CNT_W-1:0] cnt_bubble_q;
   logic             any_bubble;

   assign any_bubble = (stl.pc == BUBBLE) || (stl.if_id == BUBBLE) || (stl.id_ex == BUBBLE) ||
                       (stl.ex_mem == BUBBLE) || (stl.mem_wb == BUBBLE);

   // saturating: a wrapped counter would silently misreport long runs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_stall_q  <= '0;
         cnt_bubble_q <= '0;
      end else begin
         if ((stl.pc == STALL) && (cnt_stall_q != '1)) begin
            cnt_stall_q <= cnt_stall_q + 1'b1;
         end
         if (any_bubble && (cnt_bubble_q != '1)) begin
            cnt_bubble_q <= cnt_bubble_q + 1'b1;
         end
      end
   end

   assign cnt_stall_o  = cnt_stall_q;
   assign cnt_bubble_o = cnt_bubble_q;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: per-cycle comparison against a behavioural model plus hand-computed spot checks.
module tb_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       ld, u1, u2, br, req_if, req_mem, done;
   logic [4:0] rd, rs1, rs2;
   logic       gnt_if, gnt_mem;
   logic [1:0] s_pc, s_ifid, s_idex, s_exmem, s_memwb;
`ifdef STALL_PERF_CNT_EN
   logic [31:0] cnt_stall, cnt_bubble;
`endif

   int checks   = 0;
   int failures = 0;
   bit armed    = 1'b0;

   localparam int OWN_NONE = 0;
   localparam int OWN_IF   = 1;
   localparam int OWN_MEM  = 2;

   // model: who owns the memory port, whether the running fetch is stale, counters
   int     owner = OWN_NONE;
   bit     stale = 1'b0;
   longint m_cs  = 0;
   longint m_cb  = 0;

   stall_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .ld_EX_i        (ld),
      .rd_EX_i        (rd),
      .rs1_ID_i       (rs1),
      .rs2_ID_i       (rs2),
      .rs1_use_ID_i   (u1),
      .rs2_use_ID_i   (u2),
      .br_EX_i        (br),
      .req_IF_i       (req_if),
      .req_MEM_i      (req_mem),
      .done_MEMCTRL_i (done),
      .gnt_IF_o       (gnt_if),
      .gnt_MEM_o      (gnt_mem),
      .stl_PC_o       (s_pc),
      .stl_IF_ID_o    (s_ifid),
      .stl_ID_EX_o    (s_idex),
      .stl_EX_MEM_o   (s_exmem),
      .stl_MEM_WB_o   (s_memwb)
`ifdef STALL_PERF_CNT_EN
      ,
      .cnt_stall_o    (cnt_stall),
      .cnt_bubble_o   (cnt_bubble)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // expected codes {PC, IF_ID, ID_EX, EX_MEM, MEM_WB} from the priority rules
   function automatic logic [9:0] exp_codes();
      bit mem_wait, fetch_done, fetch_wait, hazard;
      mem_wait   = (owner == OWN_MEM && !done) || (owner == OWN_NONE && req_mem);
      fetch_done = (owner == OWN_IF) && done;
      fetch_wait = (req_if || owner == OWN_IF) && !fetch_done;
      hazard     = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (rst)                      return {5{2'b10}};
      if (mem_wait)                 return {2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      if (br)                       return {2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
      if (fetch_wait)               return {2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
      if (fetch_done && stale)      return {2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
      if (hazard)                   return {2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
      return 10'b0;
   endfunction

   always @(posedge clk) begin
      logic [9:0] e;
      e = exp_codes();
      if (rst) begin
         owner = OWN_NONE;
         stale = 1'b0;
         m_cs  = 0;
         m_cb  = 0;
         armed = 1'b1;
      end else begin
         if (e[9:8] == 2'b01 && m_cs < 64'hFFFF_FFFF) m_cs++;
         if ((e[9:8] == 2'b10 || e[7:6] == 2'b10 || e[5:4] == 2'b10 ||
              e[3:2] == 2'b10 || e[1:0] == 2'b10) && m_cb < 64'hFFFF_FFFF) m_cb++;
         if (owner == OWN_NONE) begin
            if (req_mem) owner = OWN_MEM;
            else if (req_if) begin
               owner = OWN_IF;
               stale = br;
            end
         end else if (owner == OWN_IF) begin
            if (done) begin
               owner = OWN_NONE;
               stale = 1'b0;
            end else if (br) stale = 1'b1;
         end else if (done) owner = OWN_NONE;
      end
   end

   always @(negedge clk) begin
      logic [9:0] e;
      if (armed) begin
         e = exp_codes();
         chk("stl_PC", s_pc, e[9:8]);
         chk("stl_IF_ID", s_ifid, e[7:6]);
         chk("stl_ID_EX", s_idex, e[5:4]);
         chk("stl_EX_MEM", s_exmem, e[3:2]);
         chk("stl_MEM_WB", s_memwb, e[1:0]);
         chk("gnt_IF", gnt_if, owner == OWN_IF);
         chk("gnt_MEM", gnt_mem, owner == OWN_MEM);
`ifdef STALL_PERF_CNT_EN
         chk("cnt_stall", cnt_stall, m_cs[31:0]);
         chk("cnt_bubble", cnt_bubble, m_cb[31:0]);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic clear();
      ld = 0; u1 = 0; u2 = 0; br = 0; req_if = 0; req_mem = 0; done = 0;
      rd = 0; rs1 = 0; rs2 = 0;
   endtask

   initial begin
      rst = 1;
      clear();
      step();
      settle();
      chk("rst_pc", s_pc, 2'b10);
      chk("rst_memwb", s_memwb, 2'b10);
      chk("rst_gnt_mem", gnt_mem, 1'b0);

      // load-use through rs2, then rd=x0, then rs1, then rs1 unused
      step(); rst = 0; ld = 1; rd = 5; rs2 = 5; u2 = 1; settle();
      chk("lu_pc", s_pc, 2'b01); chk("lu_ifid", s_ifid, 2'b01); chk("lu_idex", s_idex, 2'b10);
      step(); rd = 0; settle();
      chk("lu_x0_pc", s_pc, 2'b00); chk("lu_x0_idex", s_idex, 2'b00);
      step(); rd = 7; rs1 = 7; u1 = 1; rs2 = 0; u2 = 0; settle();
      step(); u1 = 0; settle();
      chk("lu_nouse_pc", s_pc, 2'b00);

      // three-cycle fetch
      step(); clear(); req_if = 1; settle();
      chk("f0_pc", s_pc, 2'b01); chk("f0_ifid", s_ifid, 2'b10); chk("f0_gnt", gnt_if, 1'b0);
      step(); settle(); chk("f1_gnt", gnt_if, 1'b1);
      step(); settle();
      step(); done = 1; settle();
      chk("f3_pc", s_pc, 2'b00); chk("f3_gnt", gnt_if, 1'b1);
      step(); done = 0; req_if = 0; settle(); chk("f4_gnt", gnt_if, 1'b0);

      // simultaneous requests: MEM first, IF taken from IDLE afterwards
      step(); req_if = 1; req_mem = 1; settle();
      chk("tie_exmem", s_exmem, 2'b01); chk("tie_memwb", s_memwb, 2'b10);
      step(); settle(); chk("tie_gmem", gnt_mem, 1'b1); chk("tie_gif0", gnt_if, 1'b0);
      step(); done = 1; req_mem = 0; settle(); chk("tie_done_pc", s_pc, 2'b01);
      step(); done = 0; settle(); chk("tie_gmem_off", gnt_mem, 1'b0);
      step(); settle(); chk("tie_gif", gnt_if, 1'b1);
      step(); done = 1; settle();

      // branch in cycle 1 of a fetch: fetched instruction is dropped
      step(); clear(); req_if = 1; settle();
      step(); br = 1; settle();
      chk("br_pc", s_pc, 2'b00); chk("br_ifid", s_ifid, 2'b10); chk("br_idex", s_idex, 2'b10);
      step(); br = 0; settle(); chk("brw_pc", s_pc, 2'b01);
      step(); done = 1; settle();
      chk("fl_pc", s_pc, 2'b00); chk("fl_ifid", s_ifid, 2'b10); chk("fl_idex", s_idex, 2'b00);
      step(); done = 0; req_if = 0; settle(); chk("fl_clr_ifid", s_ifid, 2'b00);
      step(); req_if = 1; settle();
      step(); done = 1; settle(); chk("nf_ifid", s_ifid, 2'b00);

      // branch and load-use together
      step(); clear(); br = 1; ld = 1; rd = 3; rs1 = 3; u1 = 1; settle();
      chk("bl_pc", s_pc, 2'b00); chk("bl_ifid", s_ifid, 2'b10); chk("bl_idex", s_idex, 2'b10);

      // branch held through a MEM wait, applied on the done cycle
      step(); clear(); req_mem = 1; br = 1; settle(); chk("bm_idex", s_idex, 2'b01);
      step(); settle();
      step(); done = 1; req_mem = 0; settle(); chk("bm_done_idex", s_idex, 2'b10);

      // done while IDLE is ignored
      step(); clear(); done = 1; settle(); chk("idle_done_pc", s_pc, 2'b00);
      step(); done = 0; settle();
      chk("idle_done_gif", gnt_if, 1'b0); chk("idle_done_gmem", gnt_mem, 1'b0);

      // reset during SRV_MEM, with a done arriving inside reset
      step(); req_mem = 1; settle();
      step(); settle(); chk("rm_gnt", gnt_mem, 1'b1);
      step(); rst = 1; done = 1; settle();
      chk("rm_pc", s_pc, 2'b10); chk("rm_exmem", s_exmem, 2'b10); chk("rm_memwb", s_memwb, 2'b10);
      step(); rst = 0; done = 0; req_mem = 0; settle();
      chk("rm_gnt_after", gnt_mem, 1'b0); chk("rm_pc_after", s_pc, 2'b00);
`ifdef STALL_PERF_CNT_EN
      chk("rm_cnt_stall", cnt_stall, 32'd0); chk("rm_cnt_bubble", cnt_bubble, 32'd0);
`endif
      step(); done = 1; settle(); chk("post_rst_gmem", gnt_mem, 1'b0);
      step(); clear(); settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
